alu_dual_rail_master: RTL and testbench

- Clocked initiator for the asynchronous dual-rail ALU stage: the other end of its four-phase NULL/DATA handshake.
- Accepts binary operands via valid/ready and encodes them to dual-rail. Drives the DATA wavefront, then the NULL wavefront.
- Synchronizes and completion-detects the stage's dual-rail result, then returns it as binary on a valid/ready output.
- Sits between synchronous test/host logic and the estagio ALU pipeline.

---
 rtl/alu_dual_rail_master_pkg.sv | 51 +++++
 rtl/alu_dual_rail_master_if.sv | 35 +++
 rtl/alu_dual_rail_master_sync.sv | 42 ++++
 rtl/alu_dual_rail_master.sv | 125 ++++++++++++
 tb/tb_alu_dual_rail_master.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_dual_rail_master_pkg.sv
// dr_alu_pkg: rail codes, FSM states and dual-rail encode/decode/completion helpers
package dr_alu_pkg;
    localparam int MAXP = 32;
    localparam logic [1:0] RAIL_NULL = 2'b00;
    localparam logic [1:0] RAIL_D0 = 2'b01;
    localparam logic [1:0] RAIL_D1 = 2'b10;
    localparam logic [1:0] RAIL_ILL = 2'b11;
    typedef enum logic [1:0] {ST_IDLE, ST_DATA, ST_NULL, ST_ERR} state_e;
    typedef logic [2*MAXP-1:0] rail_t;
    typedef logic [MAXP-1:0] bin_t;

    function automatic rail_t dr_encode(bin_t v, int n);
        rail_t r;
        r = '0;
        for (int i = 0; i < MAXP; i++)
            if (i < n) r[2*i +: 2] = v[i] ? RAIL_D1 : RAIL_D0;
        return r;
    endfunction

    function automatic bin_t dr_decode(rail_t r, int n);
        bin_t v;
        v = '0;
        for (int i = 0; i < MAXP; i++)
            if (i < n) v[i] = r[2*i +: 2] == RAIL_D1;
        return v;
    endfunction

    function automatic logic dr_complete(rail_t r, int n);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < MAXP; i++)
            if (i < n && (r[2*i +: 2] == RAIL_NULL || r[2*i +: 2] == RAIL_ILL)) ok = 1'b0;
        return ok;
    endfunction

    function automatic logic dr_is_null(rail_t r, int n);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < MAXP; i++)
            if (i < n && r[2*i +: 2] != RAIL_NULL) ok = 1'b0;
        return ok;
    endfunction

    function automatic logic dr_has_illegal(rail_t r, int n);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < MAXP; i++)
            if (i < n && r[2*i +: 2] == RAIL_ILL) hit = 1'b1;
        return hit;
    endfunction
endpackage

// File: rtl/alu_dual_rail_master_if.sv
// alu_dual_rail_master_if: host valid/ready buses plus the dual-rail stage wires
interface alu_dual_rail_master_if #(
    parameter int W = 4
);
    logic in_valid;
    logic in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic in_op;
    logic [2*W-1:0] a;
    logic [2*W-1:0] b;
    logic [1:0] opr;
    logic ack_in;
    logic [2*W-1:0] soma;
    logic [1:0] of;
    logic [1:0] neg;
    logic [1:0] zero;
    logic ack_out;
    logic out_valid;
    logic out_ready;
    logic [W-1:0] out_res;
    logic out_of;
    logic out_neg;
    logic out_zero;
    logic err;

    modport master (
        input in_valid, in_a, in_b, in_op, soma, of, neg, zero, ack_out, out_ready,
        output in_ready, a, b, opr, ack_in, out_valid, out_res, out_of, out_neg, out_zero, err
    );
    modport slave (
        output in_valid, in_a, in_b, in_op, soma, of, neg, zero, ack_out, out_ready,
        input in_ready, a, b, opr, ack_in, out_valid, out_res, out_of, out_neg, out_zero, err
    );
endinterface

// File: rtl/alu_dual_rail_master_sync.sv
// dr_sync_completion: synchronizer chain with a two-cycle stability filter for completion/null/illegal
module dr_sync_completion
    import dr_alu_pkg::*;
#(
    parameter int N = 2,
    parameter int SYNC_STAGES = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] din,
    output logic [N-1:0] value,
    output logic         complete,
    output logic         is_null,
    output logic         illegal
);
    logic [SYNC_STAGES-1:0][N-1:0] sync_q, sync_d;
    logic [N-1:0] prev_q, prev_d;
    logic stable;

    always_comb begin
        sync_d[0] = din;
        for (int i = 1; i < SYNC_STAGES; i++) sync_d[i] = sync_q[i-1];
        prev_d = sync_q[SYNC_STAGES-1];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q <= '0;
            prev_q <= '0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign value = sync_q[SYNC_STAGES-1];
    assign stable = value == prev_q;
    assign complete = stable && dr_complete(rail_t'(value), N / 2);
    assign is_null = stable && dr_is_null(rail_t'(value), N / 2);
    // a pair reads 11 in both cycles only if it survives the AND of the two samples
    assign illegal = dr_has_illegal(rail_t'(value & prev_q), N / 2);
endmodule

// File: rtl/alu_dual_rail_master.sv
// alu_dual_rail_master: clocked four-phase NULL/DATA initiator for the dual-rail ALU stage
module alu_dual_rail_master
    import dr_alu_pkg::*;
#(
    parameter int W = 4,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT = 255
) (
    input logic clk,
    input logic rst_n,
    alu_dual_rail_master_if.master bus
);
    localparam int RN = 2 * (W + 3);
    localparam int CW = $clog2(TIMEOUT + 1);

    state_e state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2*W-1:0] a_q, a_d, b_q, b_d;
    logic [1:0] opr_q, opr_d;
    logic ack_in_q, ack_in_d;
    logic in_ready_q, in_ready_d;
    logic out_valid_q, out_valid_d;
    logic err_q, err_d;
    logic [W-1:0] res_q, res_d;
    logic of_q, of_d, neg_q, neg_d, zero_q, zero_d;
    logic [RN-1:0] res_v;
    logic [W+2:0] dec;
    logic res_complete, res_null, res_illegal, ack_s;
    logic ack_unused_c, ack_unused_n, ack_unused_i;
    logic accept, timeout, capture;

    dr_sync_completion #(.N(RN), .SYNC_STAGES(SYNC_STAGES)) u_res (
        .clk(clk),
        .rst_n(rst_n),
        .din({bus.soma, bus.of, bus.neg, bus.zero}),
        .value(res_v),
        .complete(res_complete),
        .is_null(res_null),
        .illegal(res_illegal)
    );

    dr_sync_completion #(.N(1), .SYNC_STAGES(SYNC_STAGES)) u_ack (
        .clk(clk),
        .rst_n(rst_n),
        .din(bus.ack_out),
        .value(ack_s),
        .complete(ack_unused_c),
        .is_null(ack_unused_n),
        .illegal(ack_unused_i)
    );

    assign accept = bus.in_valid && in_ready_q;
    assign timeout = cnt_q == CW'(TIMEOUT - 1);
    assign capture = state_q == ST_DATA && state_d == ST_NULL;
    assign dec = (W + 3)'(dr_decode(rail_t'(res_v), W + 3));

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: state_d = res_illegal ? ST_ERR : accept ? ST_DATA : ST_IDLE;
            ST_DATA: state_d = (res_illegal || timeout) ? ST_ERR : (!ack_s && res_complete) ? ST_NULL : ST_DATA;
            ST_NULL: state_d = (res_illegal || timeout) ? ST_ERR : (ack_s && res_null) ? ST_IDLE : ST_NULL;
            default: state_d = ST_ERR;
        endcase
    end

    always_comb begin
        cnt_d = (state_d != state_q) ? '0 : (state_q == ST_DATA || state_q == ST_NULL) ? cnt_q + CW'(1) : cnt_q;
        a_d = state_d != ST_DATA ? '0 : state_q == ST_IDLE ? (2*W)'(dr_encode(bin_t'(bus.in_a), W)) : a_q;
        b_d = state_d != ST_DATA ? '0 : state_q == ST_IDLE ? (2*W)'(dr_encode(bin_t'(bus.in_b), W)) : b_q;
        opr_d = state_d != ST_DATA ? RAIL_NULL : state_q == ST_IDLE ? (bus.in_op ? RAIL_D1 : RAIL_D0) : opr_q;
        ack_in_d = state_d != ST_NULL;
        err_d = state_d == ST_ERR;
        out_valid_d = capture || (out_valid_q && !bus.out_ready);
        in_ready_d = state_d == ST_IDLE && ack_s && !out_valid_d && !err_d;
        res_d = capture ? dec[W+2:3] : res_q;
        of_d = capture ? dec[2] : of_q;
        neg_d = capture ? dec[1] : neg_q;
        zero_d = capture ? dec[0] : zero_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q <= '0;
            a_q <= '0;
            b_q <= '0;
            opr_q <= RAIL_NULL;
            ack_in_q <= 1'b1;
            in_ready_q <= 1'b0;
            out_valid_q <= 1'b0;
            err_q <= 1'b0;
            res_q <= '0;
            of_q <= 1'b0;
            neg_q <= 1'b0;
            zero_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q <= cnt_d;
            a_q <= a_d;
            b_q <= b_d;
            opr_q <= opr_d;
            ack_in_q <= ack_in_d;
            in_ready_q <= in_ready_d;
            out_valid_q <= out_valid_d;
            err_q <= err_d;
            res_q <= res_d;
            of_q <= of_d;
            neg_q <= neg_d;
            zero_q <= zero_d;
        end
    end

    assign bus.a = a_q;
    assign bus.b = b_q;
    assign bus.opr = opr_q;
    assign bus.ack_in = ack_in_q;
    assign bus.in_ready = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.err = err_q;
    assign bus.out_res = res_q;
    assign bus.out_of = of_q;
    assign bus.out_neg = neg_q;
    assign bus.out_zero = zero_q;
endmodule

// File: tb/tb_alu_dual_rail_master.sv
// tb_alu_dual_rail_master: directed vectors against a behavioural dual-rail stage, scoreboard-checked
module tb_alu_dual_rail_master;
    import dr_alu_pkg::*;
    localparam int W = 4;
    localparam int TIMEOUT = 255;
    localparam int NORMAL = 0, GLITCH = 1, STALL = 2, ILL = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int total = 0;
    int bad = 0;
    int mode = NORMAL;
    logic [6:0] exp_q[$];
    logic [6:0] mon_e;
    logic glitch_q = 1'b0;
    logic [3:0] sa, sb, sr;
    logic sop, sof;
    logic [7:0] sr_enc;

    logic [3:0] va[11] = '{4'd1, 4'd6, 4'd8, 4'd0, 4'd15, 4'd9, 4'd4, 4'd2, 4'd12, 4'd7, 4'd10};
    logic [3:0] vb[11] = '{4'd1, 4'd5, 4'd1, 4'd1, 4'd1, 4'd9, 4'd2, 4'd4, 4'd3, 4'd8, 4'd6};
    logic vo[11] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [6:0] ve[11] = '{{4'd2, 3'b000}, {4'd11, 3'b110}, {4'd7, 3'b100}, {4'd15, 3'b010},
                           {4'd0, 3'b001}, {4'd2, 3'b100}, {4'd2, 3'b000}, {4'd14, 3'b010},
                           {4'd15, 3'b010}, {4'd15, 3'b110}, {4'd0, 3'b001}};

    alu_dual_rail_master_if #(.W(W)) bus ();

    alu_dual_rail_master #(.W(W), .SYNC_STAGES(2), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] dec4(logic [7:0] r);
        logic [3:0] v;
        for (int i = 0; i < 4; i++) v[i] = r[2*i+1];
        return v;
    endfunction

    function automatic logic [7:0] enc4(logic [3:0] v);
        logic [7:0] r;
        for (int i = 0; i < 4; i++) r[2*i +: 2] = v[i] ? 2'b10 : 2'b01;
        return r;
    endfunction

    function automatic logic full8(logic [7:0] r);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < 4; i++) if (!(r[2*i] ^ r[2*i+1])) ok = 1'b0;
        return ok;
    endfunction

    // behavioural asynchronous stage, reacting on the falling edge
    always_comb begin
        sa = dec4(bus.a);
        sb = dec4(bus.b);
        sop = bus.opr[1];
        sr = sop ? sa - sb : sa + sb;
        sof = sop ? (sa[3] != sb[3] && sr[3] != sa[3]) : (sa[3] == sb[3] && sr[3] != sa[3]);
        sr_enc = enc4(sr);
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            bus.ack_out <= 1'b1;
            bus.soma <= '0;
            bus.of <= 2'b00;
            bus.neg <= 2'b00;
            bus.zero <= 2'b00;
            glitch_q <= 1'b0;
        end else if (glitch_q) begin
            bus.soma <= sr_enc;
            glitch_q <= 1'b0;
        end else if (bus.ack_out && bus.ack_in && full8(bus.a) && full8(bus.b) && (^bus.opr) && mode != STALL) begin
            bus.soma <= (mode == NORMAL) ? sr_enc : {sr_enc[7:2], 2'b11};
            bus.of <= sof ? 2'b10 : 2'b01;
            bus.neg <= sr[3] ? 2'b10 : 2'b01;
            bus.zero <= (sr == 4'd0) ? 2'b10 : 2'b01;
            bus.ack_out <= 1'b0;
            glitch_q <= mode == GLITCH;
        end else if (!bus.ack_out && !bus.ack_in && bus.a == 8'd0 && bus.b == 8'd0 && bus.opr == 2'b00) begin
            bus.soma <= '0;
            bus.of <= 2'b00;
            bus.neg <= 2'b00;
            bus.zero <= 2'b00;
            bus.ack_out <= 1'b1;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, req);
        end
    endtask

    // scoreboard monitor: samples just before the rising edge where the handshake lands
    always begin
        @(negedge clk);
        #4;
        if (rst_n && bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) chk("result_unexpected", 32'(exp_q.size()), 32'(1));
            else begin
                mon_e = exp_q.pop_front();
                chk("result", 32'({bus.out_res, bus.out_of, bus.out_neg, bus.out_zero}), 32'(mon_e));
            end
        end
    end

    function automatic logic probe(int s);
        case (s)
            0: return bus.out_valid;
            1: return bus.ack_in;
            2: return bus.err;
            3: return bus.in_ready;
            default: return exp_q.size() == 0;
        endcase
    endfunction

    task automatic wait_for(input int s, input int lim, input string nm, output int n);
        n = 0;
        while (!probe(s) && n < lim) begin
            @(negedge clk);
            n++;
        end
        if (!probe(s)) chk(nm, 32'(probe(s)), 32'(1));
    endtask

    task automatic issue(input logic [3:0] x, input logic [3:0] y, input logic op, input logic [6:0] e, input bit push);
        int n;
        n = 0;
        bus.in_a = x;
        bus.in_b = y;
        bus.in_op = op;
        bus.in_valid = 1'b1;
        while (!bus.in_ready && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (!bus.in_ready) chk("accept_timeout", 32'(bus.in_ready), 32'(1));
        @(negedge clk);
        bus.in_valid = 1'b0;
        if (push) exp_q.push_back(e);
    endtask

    task automatic chk_null(input string t);
        chk({t, "_a"}, 32'(bus.a), 0);
        chk({t, "_b"}, 32'(bus.b), 0);
        chk({t, "_opr"}, 32'(bus.opr), 0);
        chk({t, "_ack_in"}, 32'(bus.ack_in), 1);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        mode = NORMAL;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int n;
        bus.in_valid = 1'b0;
        bus.in_a = '0;
        bus.in_b = '0;
        bus.in_op = 1'b0;
        bus.out_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk_null("rst");
        chk("rst_in_ready", 32'(bus.in_ready), 0);
        chk("rst_out_valid", 32'(bus.out_valid), 0);
        chk("rst_err", 32'(bus.err), 0);
        chk("rst_out", 32'({bus.out_res, bus.out_of, bus.out_neg, bus.out_zero}), 0);
        rst_n = 1'b1;

        issue(4'd3, 4'd4, 1'b0, {4'd7, 3'b000}, 1'b1);
        chk("wave_a", 32'(bus.a), 32'(8'b01011010));
        chk("wave_b", 32'(bus.b), 32'(8'b01100101));
        chk("wave_opr", 32'(bus.opr), 32'(2'b01));
        chk("wave_ack_in", 32'(bus.ack_in), 1);
        wait_for(0, 100, "add_valid_timeout", n);
        chk("done_ack_in_low", 32'(bus.ack_in), 0);
        wait_for(1, 100, "add_null_timeout", n);
        chk_null("add_return");

        issue(4'd5, 4'd5, 1'b1, {4'd0, 3'b001}, 1'b1);
        issue(4'd7, 4'd1, 1'b0, {4'd8, 3'b110}, 1'b1);
        wait_for(4, 200, "drain1", n);

        bus.out_ready = 1'b0;
        issue(4'd1, 4'd2, 1'b0, {4'd3, 3'b000}, 1'b1);
        wait_for(0, 100, "bp_valid_timeout", n);
        bus.in_a = 4'd2;
        bus.in_b = 4'd2;
        bus.in_op = 1'b0;
        bus.in_valid = 1'b1;
        n = 0;
        repeat (30) begin
            @(negedge clk);
            if (bus.in_ready || bus.a != 8'd0) n++;
        end
        chk("bp_blocked", 32'(n), 0);
        chk("bp_valid_held", 32'(bus.out_valid), 1);
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk("bp_valid_drop", 32'(bus.out_valid), 0);
        issue(4'd2, 4'd2, 1'b0, {4'd4, 3'b000}, 1'b1);
        chk("bp_second_wave", 32'(bus.a), 32'(8'b01011001));
        wait_for(4, 200, "drain2", n);

        wait_for(3, 100, "idle_glitch", n);
        mode = GLITCH;
        issue(4'd6, 4'd1, 1'b0, {4'd7, 3'b000}, 1'b1);
        wait_for(4, 200, "drain_glitch", n);
        chk("glitch_no_err", 32'(bus.err), 0);
        mode = NORMAL;

        wait_for(3, 100, "idle_stall", n);
        mode = STALL;
        issue(4'd1, 4'd1, 1'b0, 7'd0, 1'b0);
        chk("stall_wave", 32'(bus.a), 32'(8'b01010110));
        wait_for(2, TIMEOUT + 20, "stall_err_timeout", n);
        chk("timeout_cycles", 32'(n), 32'(TIMEOUT));
        chk_null("timeout");
        chk("timeout_in_ready", 32'(bus.in_ready), 0);
        do_reset();

        mode = ILL;
        issue(4'd2, 4'd3, 1'b0, 7'd0, 1'b0);
        wait_for(2, 50, "ill_err_timeout", n);
        chk("ill_state", 32'(dut.state_q), 32'(ST_ERR));
        chk_null("ill");
        chk("ill_in_ready", 32'(bus.in_ready), 0);
        do_reset();

        issue(4'd3, 4'd3, 1'b0, 7'd0, 1'b0);
        chk("mid_state_data", 32'(dut.state_q), 32'(ST_DATA));
        rst_n = 1'b0;
        @(negedge clk);
        chk_null("rst_mid");
        chk("rst_mid_out_valid", 32'(bus.out_valid), 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 11; i++) issue(va[i], vb[i], vo[i], ve[i], 1'b1);
        wait_for(4, 500, "drain_b2b", n);
        chk("drain_empty", 32'(exp_q.size()), 0);
        chk("final_err", 32'(bus.err), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
